// File: rtl/keypad_event_queue.sv
// keypad_event_queue
// Takes the keypad controller's valid_key/key pair into the clk domain, turns
// each press into exactly one event carrying a mole index (0..8), buffers the
// events in a small FIFO with a valid/ready consumer, and re-arms the
// controller after each capture with a low pulse on kp_clear_n.
//
// Build option: define KEYQ_TIMESTAMP_EN to store a 16-bit cycle-count
// timestamp with each event. When undefined, evt_time is tied to zero.
//
// Ports:
//   clk         system clock
//   reset       asynchronous reset, active low
//   valid_key   controller key-valid level (asynchronous to clk)
//   key         controller key code {column[1:0], row[1:0]} (asynchronous)
//   kp_clear_n  controller clear, active low (held low during reset)
//   evt_valid   FIFO head valid
//   evt_ready   consumer accepts head on evt_valid & evt_ready
//   evt_mole    mole index of the head entry
//   evt_time    timestamp of the head entry (zero without KEYQ_TIMESTAMP_EN)
//   overflow    sticky, an event was dropped on a full FIFO
//   bad_code    sticky, a code with column 3 or row 3 was received
//   flag_clr    clears the sticky flags (a same-cycle set wins)
//
// FSM states:
//   state    | meaning
//   IDLE     | waiting for a rising edge of the synchronised valid_key
//   CAPTURE  | decode key_s, push the event (or flag a bad code)
//   CLEAR    | kp_clear_n low for CLR_CYCLES cycles
//   WAIT_LOW | wait for the controller to drop valid_key before re-arming

module keypad_event_queue #(
    parameter int DEPTH      = 4,
    parameter int CLR_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_key,
    input  logic [3:0]  key,
    output logic        kp_clear_n,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [3:0]  evt_mole,
    output logic [15:0] evt_time,
    output logic        overflow,
    output logic        bad_code,
    input  logic        flag_clr
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        CLEAR    = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  clr_cnt, clr_cnt_nxt;
    logic        armed;

    logic        vk_m, vk_s, vk_q;
    logic [3:0]  key_m, key_s;

    logic [1:0]  col, row;
    logic        code_bad;
    logic [3:0]  mole;

    logic [AW:0] wptr, rptr;
    logic [3:0]  mole_mem [DEPTH];
    logic        full, empty;
    logic        capture, push, pop, wr_en, drop;

    // Two-flop synchronisers; vk_q is one more stage used only for edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vk_m  <= 1'b0;
            vk_s  <= 1'b0;
            vk_q  <= 1'b0;
            key_m <= 4'd0;
            key_s <= 4'd0;
        end else begin
            vk_m  <= valid_key;
            vk_s  <= vk_m;
            vk_q  <= vk_s;
            key_m <= key;
            key_s <= key_m;
        end
    end

    // armed keeps the controller in clear until the first edge after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            clr_cnt <= 4'd0;
            armed   <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            armed   <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        kp_clear_n  = armed;
        case (state)
            IDLE: begin
                if (vk_s && !vk_q)
                    state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt   = CLEAR;
                clr_cnt_nxt = 4'(CLR_CYCLES);
            end
            CLEAR: begin
                kp_clear_n = 1'b0;
                if (clr_cnt == 4'd1)
                    state_nxt = WAIT_LOW;
                else
                    clr_cnt_nxt = clr_cnt - 4'd1;
            end
            WAIT_LOW: begin
                if (!vk_s)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign col      = key_s[3:2];
    assign row      = key_s[1:0];
    assign code_bad = (col == 2'd3) || (row == 2'd3);
    assign mole     = ({2'b00, col} * 4'd3) + {2'b00, row};

    assign capture = (state == CAPTURE);
    assign push    = capture && !code_bad;
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop     = evt_valid && evt_ready;
    // A push into a full FIFO still lands when the head is leaving this cycle.
    assign wr_en   = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++)
                mole_mem[i] <= 4'd0;
        end else begin
            if (wr_en) begin
                mole_mem[wptr[AW-1:0]] <= mole;
                wptr <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    assign evt_valid = !empty;
    assign evt_mole  = mole_mem[rptr[AW-1:0]];

`ifdef KEYQ_TIMESTAMP_EN
    logic [15:0] ts_cnt;
    logic [15:0] time_mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_cnt <= 16'd0;
            for (int i = 0; i < DEPTH; i++)
                time_mem[i] <= 16'd0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
            if (wr_en)
                time_mem[wptr[AW-1:0]] <= ts_cnt;
        end
    end

    assign evt_time = time_mem[rptr[AW-1:0]];
`else
    assign evt_time = 16'h0000;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            bad_code <= 1'b0;
        end else begin
            overflow <= drop || (overflow && !flag_clr);
            bad_code <= (capture && code_bad) || (bad_code && !flag_clr);
        end
    end

endmodule

// File: tb/tb_keypad_event_queue.sv
module tb_keypad_event_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_key;
    logic [3:0]  key;
    logic        kp_clear_n;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_mole;
    logic [15:0] evt_time;
    logic        overflow;
    logic        bad_code;
    logic        flag_clr;

    int checks = 0;
    int errors = 0;

    logic [3:0]  exp_q[$];
    logic [15:0] t_q[$];

    // Hand-computed mole index per code, 15 marks an invalid code.
    logic [3:0] mole_tab [16] = '{4'd0, 4'd1, 4'd2, 4'd15,
                                  4'd3, 4'd4, 4'd5, 4'd15,
                                  4'd6, 4'd7, 4'd8, 4'd15,
                                  4'd15, 4'd15, 4'd15, 4'd15};

    keypad_event_queue #(.DEPTH(4), .CLR_CYCLES(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_key  (valid_key),
        .key        (key),
        .kp_clear_n (kp_clear_n),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_mole   (evt_mole),
        .evt_time   (evt_time),
        .overflow   (overflow),
        .bad_code   (bad_code),
        .flag_clr   (flag_clr)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Monitor: every accepted head is compared against the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got mole %0d expected no event", evt_mole);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (evt_mole !== e) begin
                    errors++;
                    $display("FAIL event_mole: got %0d expected %0d", evt_mole, e);
                end
            end
            t_q.push_back(evt_time);
`ifndef KEYQ_TIMESTAMP_EN
            checks++;
            if (evt_time !== 16'h0000) begin
                errors++;
                $display("FAIL event_time_zero: got %0d expected 0", evt_time);
            end
`endif
        end
    end

    // Called just after a posedge; takes exactly 14 clock edges.
    task automatic press(input logic [3:0] k, input bit pop_at_cap);
        key       = k;
        valid_key = 1'b1;
        repeat (3) @(posedge clk);
        if (pop_at_cap) begin
            #1 evt_ready = 1'b1;
        end
        @(posedge clk);
        if (pop_at_cap) begin
            #1 evt_ready = 1'b0;
        end
        repeat (5) @(posedge clk);
        #1 valid_key = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ov_keys [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101};
        logic [3:0] fl_keys [4] = '{4'b0110, 4'b1000, 4'b1001, 4'b1010};
        logic [3:0] fl_mole [4] = '{4'd5, 4'd6, 4'd7, 4'd8};

        reset = 1'b0; valid_key = 1'b0; key = 4'd0; evt_ready = 1'b0; flag_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_mole", evt_mole, 0);
        chk("rst_evt_time", evt_time, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_bad_code", bad_code, 0);
        chk("rst_kp_clear_n", kp_clear_n, 0);
        reset = 1'b1;
        #2 chk("rel_kp_clear_n_before_edge", kp_clear_n, 0);
        @(posedge clk); #1;
        chk("rel_kp_clear_n_after_edge", kp_clear_n, 1);

        // Single press, code 0110 -> mole 5, 4 edges of latency.
        exp_q.push_back(4'd5);
        key = 4'b0110;
        valid_key = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            chk($sformatf("single_valid_e%0d", e), evt_valid, (e >= 4) ? 1 : 0);
            chk($sformatf("single_clr_e%0d", e), kp_clear_n, (e >= 4 && e <= 6) ? 0 : 1);
            if (e == 4) chk("single_mole", evt_mole, 5);
        end
        repeat (10) @(posedge clk);
        #1 evt_ready = 1'b1;
        @(posedge clk);
        #1 evt_ready = 1'b0;
        chk("single_no_second_event", evt_valid, 0);
        valid_key = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Decode sweep of all 16 codes with the consumer always ready.
        evt_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (mole_tab[k] != 4'd15) exp_q.push_back(mole_tab[k]);
            press(4'(k), 1'b0);
            if (k == 2) chk("sweep_bad_before", bad_code, 0);
            if (k == 3) chk("sweep_bad_after", bad_code, 1);
        end
        chk("sweep_queue_empty", evt_valid, 0);
        chk("sweep_no_overflow", overflow, 0);
        evt_ready = 1'b0;
        flag_clr = 1'b1;
        @(posedge clk);
        #1 flag_clr = 1'b0;
        chk("sweep_bad_cleared", bad_code, 0);

        // Overflow: five presses into a four-entry FIFO.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(mole_tab[ov_keys[i]]);
            press(ov_keys[i], 1'b0);
            if (i == 3) chk("ovf_not_yet", overflow, 0);
            if (i == 4) chk("ovf_set", overflow, 1);
        end
        chk("ovf_head", evt_mole, 0);
        evt_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 evt_ready = 1'b0;
        chk("ovf_drained", evt_valid, 0);
        flag_clr = 1'b1;
        @(posedge clk);
        #1 flag_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Full FIFO with a pop in the same cycle as the push.
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(fl_mole[i]);
            press(fl_keys[i], 1'b0);
        end
        exp_q.push_back(4'd0);
        press(4'b0000, 1'b1);
        chk("full_pop_no_overflow", overflow, 0);
        chk("full_pop_head", evt_mole, 6);
        evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 evt_ready = 1'b0;
        chk("full_pop_count3", evt_valid, 1);
        chk("full_pop_last", evt_mole, 0);
        evt_ready = 1'b1;
        @(posedge clk);
        #1 evt_ready = 1'b0;
        chk("full_pop_count4", evt_valid, 0);

        // Timestamps: two presses exactly 100 cycles apart.
        t_q.delete();
        evt_ready = 1'b1;
        exp_q.push_back(4'd1);
        press(4'b0001, 1'b0);
        repeat (86) @(posedge clk);
        #1;
        exp_q.push_back(4'd2);
        press(4'b0010, 1'b0);
        evt_ready = 1'b0;
        chk("ts_event_count", t_q.size(), 2);
`ifdef KEYQ_TIMESTAMP_EN
        if (t_q.size() == 2) chk("ts_delta", 32'(t_q[1] - t_q[0]), 100);
`else
        chk("ts_port_zero", evt_time, 0);
`endif

        // Reset in the middle of a clear pulse with events queued.
        exp_q.push_back(4'd3);
        press(4'b0100, 1'b0);
        key = 4'b0101;
        valid_key = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_in_clear", kp_clear_n, 0);
        chk("mid_two_queued", evt_valid, 1);
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", evt_valid, 0);
        chk("mid_rst_mole", evt_mole, 0);
        chk("mid_rst_clear_n", kp_clear_n, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_bad", bad_code, 0);
        valid_key = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rel_clear_n", kp_clear_n, 1);
        chk("mid_rel_valid", evt_valid, 0);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_event_queue.md
# keypad_event_queue

Downstream stage of the keypad controller. Synchronises the controller's `valid_key`/`key[3:0]` into the system clock domain and converts each key press into a one-shot event carrying a 0–8 mole index. Events are buffered in a small FIFO with a valid/ready consumer handshake. The block re-arms the controller after each capture by pulsing the controller's active-low `clear`.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2–16.
- `CLR_CYCLES`, 3: length of the `kp_clear_n` low pulse after a capture, in clk cycles; 1–15.
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-low.
- `valid_key`  in  1  controller key-valid level; asynchronous to clk.
- `key`  in  4  controller key code: `{column[1:0], row[1:0]}`; asynchronous to clk.
- `kp_clear_n`  out  1  drives the controller's `clear`; low pulse re-arms it.
- `evt_valid`  out  1  FIFO head is valid.
- `evt_ready`  in  1  consumer accepts the head on `evt_valid & evt_ready`.
- `evt_mole`  out  4  mole index 0–8 of the head entry.
- `evt_time`  out  16  timestamp of the head entry; see Configuration.
- `overflow`  out  1  sticky: a valid event was dropped because the FIFO was full.
- `bad_code`  out  1  sticky: a code with column==3 or row==3 was received.
- `flag_clr`  in  1  synchronous; clears `overflow` and `bad_code`.

## Operation
- Synchronisation: `valid_key` and `key` each pass through two clk flops (`vk_s`, `key_s`). `key` is stable whenever `valid_key` rises, so no extra qualification is needed.
- FSM states:
  - IDLE: on rising edge of `vk_s` (`vk_s & ~vk_q`) -> CAPTURE.
  - CAPTURE: decode `key_s` and push if valid -> CLEAR; load clear counter with `CLR_CYCLES`.
  - CLEAR: `kp_clear_n`=0; decrement counter; at 1 -> WAIT_LOW.
  - WAIT_LOW: `kp_clear_n`=1; when `vk_s`==0 -> IDLE.
- Rising edges of `vk_s` outside IDLE are ignored. The FSM is a one-event-per-press guarantee.
- Decode: `col=key_s[3:2]`, `row=key_s[1:0]`, `mole = col*3 + row`, computed in 4 bits, range 0..8.
- If col==3 or row==3: no push, `bad_code` set. The FSM still goes through CLEAR.
- FIFO: `DEPTH` entries, read/write pointers of log2(DEPTH)+1 bits, wrap at DEPTH.
  - Full: pointer MSBs differ, remaining bits equal.
  - Empty: pointers equal.
  - `evt_mole`/`evt_time` show the head entry combinationally from storage; `evt_valid` = ~empty.
- Push when full with no pop in the same cycle: entry dropped, `overflow` set, FIFO contents unchanged.
- Push when full with a pop in the same cycle: both happen, count unchanged, no overflow.
- Pop while empty: ignored.
- Sticky flags: set has priority over `flag_clr` in the same cycle.

## Timing
- Reset values:
  - `kp_clear_n`=0: the controller is held in clear during reset.
  - `evt_valid`=0, `evt_mole`=0, `evt_time`=0, `overflow`=0, `bad_code`=0.
  - FSM=IDLE, pointers=0, sync flops=0.
- `kp_clear_n` rises at the first clk edge after `reset` deasserts.
- Latency, `valid_key` rise sampled at edge N:
  - `vk_s`=1 after N+1.
  - FSM=CAPTURE after N+2.
  - Entry written at N+3; `evt_valid`=1 after N+3 if the FIFO was empty.
- `kp_clear_n` is low for exactly `CLR_CYCLES` cycles, starting after edge N+3.
- Handshake:
  - Pop occurs on a clk edge with `evt_valid & evt_ready`; the next entry (if any) appears after that edge.
  - `evt_valid` does not drop without a pop.
  - Back-to-back pops are allowed every cycle.
- Reset mid-operation: asynchronous clear of all state. A pending clear pulse is abandoned and queued events are lost.

## Configuration
- `KEYQ_TIMESTAMP_EN` defined:
  - A free-running 16-bit cycle counter (reset 0, wraps 0xFFFF->0) is sampled in CAPTURE.
  - The sampled value is stored with each entry and presented on `evt_time`.
- `KEYQ_TIMESTAMP_EN` undefined:
  - Counter and per-entry timestamp storage are removed.
  - `evt_time` is tied to 16'h0000; the port is kept.

## Test plan
- Reset: assert `reset`=0 mid-run -> all outputs at reset values, `kp_clear_n`=0; after release, `kp_clear_n`=1 one edge later.
- Single press: `key`=4'b0110 (col 1, row 2), raise `valid_key` -> `evt_valid`=1 with `evt_mole`=5 exactly 4 edges later. Then `kp_clear_n` low for 3 cycles. Holding `valid_key` high produces no second event until it drops and rises again.
- Full decode sweep: all 16 codes -> 9 events in order mole 0..8. `bad_code`=1 after the first invalid code (e.g. 4'b0011). `flag_clr` clears it.
- Overflow: `evt_ready`=0, 5 presses with DEPTH=4 -> 4 entries held (moles of presses 1–4), `overflow`=1. Then 4 pops -> `evt_valid`=0.
- Full + simultaneous pop/push: FIFO full, `evt_ready`=1 in the push cycle -> no overflow, head advances, count stays 4.
- `KEYQ_TIMESTAMP_EN` defined: two presses 100 cycles apart -> `evt_time` values differ by 100. Undefined: `evt_time`=0 always.
